pipe_addsub: RTL and testbench

Parametrised, pipelined integer adder/subtractor with ready/valid flow control and ALU status flags. It splits a WIDTH-bit add into STAGES equal chunks, computing one chunk per register stage with the carry passed forward. This gives one result per cycle at a fixed latency. It replaces the 32-bit single-cycle ripple adder in datapaths that need higher clock rates, and is used as the ADD/SUB engine for the multi-cycle ALU and address generation.

---
 rtl/pipe_addsub.sv | 117 +++++++++++
 tb/tb_pipe_addsub.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined chunked adder/subtractor with ready/valid flow control and ALU flags
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_neg
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]            v_q, v_d, en;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                         ovf_q, ovf_d;

    logic [STAGES-1:0][WIDTH-1:0] a_s, b_s, s_s;
    logic [STAGES-1:0]            c_s;
    logic [CW:0]                  chunk;
    logic                         full;

    // A stage may advance when it is empty or everything downstream of it can advance.
    always_comb begin
        full = 1'b1;
        en   = '0;
        for (int k = LAST; k >= 0; k--) begin
            full  = full & v_q[k];
            en[k] = i_ready | ~full;
        end
    end

    always_comb begin
        a_s    = '0;
        b_s    = '0;
        s_s    = '0;
        c_s    = '0;
        v_d    = '0;
        a_d    = '0;
        b_d    = '0;
        sum_d  = '0;
        c_d    = '0;
        chunk  = '0;
        ovf_d  = 1'b0;

        a_s[0] = i_a;
        b_s[0] = i_op[0] ? ~i_b : i_b;
        c_s[0] = i_op[1] ? i_cin : i_op[0];
        v_d[0] = i_valid & en[0];
        for (int k = 1; k < STAGES; k++) begin
            a_s[k] = a_q[k-1];
            b_s[k] = b_q[k-1];
            s_s[k] = sum_q[k-1];
            c_s[k] = c_q[k-1];
            v_d[k] = v_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, a_s[k][k*CW +: CW]} + {1'b0, b_s[k][k*CW +: CW]}
                  + {{CW{1'b0}}, c_s[k]};
            sum_d[k]              = s_s[k];
            sum_d[k][k*CW +: CW]  = chunk[CW-1:0];
            c_d[k]                = chunk[CW];
            a_d[k]                = a_s[k];
            b_d[k]                = b_s[k];
        end

        // Carry into the MSB recovered from the MSB sum bit and its operand bits.
        ovf_d = c_d[LAST] ^ (sum_d[LAST][WIDTH-1] ^ a_s[LAST][WIDTH-1] ^ b_s[LAST][WIDTH-1]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v_q[k]   <= v_d[k];
                    c_q[k]   <= c_d[k];
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    sum_q[k] <= sum_d[k];
                end
            end
            if (en[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign o_ready = en[0];
    assign o_valid = v_q[LAST];
    assign o_sum   = sum_q[LAST];
    assign o_carry = c_q[LAST];
    assign o_ovf   = ovf_q;
    assign o_zero  = (sum_q[LAST] == '0);
    assign o_neg   = sum_q[LAST][WIDTH-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - directed and model-checked bench for pipe_addsub across several widths/depths
module tb_pipe_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid, ready_in, cin;
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        o_ready, o_valid, o_carry, o_ovf, o_zero, o_neg;
    logic [31:0] o_sum;

    logic        s_valid, s_cin;
    logic [63:0] s_a, s_b;
    logic [1:0]  s_op;
    logic        r1, v1, c1, ov1, z1, n1;
    logic        r2, v2, c2, ov2, z2, n2;
    logic        r8, v8, c8, ov8, z8, n8;
    logic [7:0]  sum1, sum2;
    logic [63:0] sum8;

    pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_a(a), .i_b(b), .i_op(op), .i_cin(cin), .o_valid(o_valid), .i_ready(ready_in),
        .o_sum(o_sum), .o_carry(o_carry), .o_ovf(o_ovf), .o_zero(o_zero), .o_neg(o_neg));

    pipe_addsub #(.WIDTH(8), .STAGES(1)) u_w8s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(r1),
        .i_a(s_a[7:0]), .i_b(s_b[7:0]), .i_op(s_op), .i_cin(s_cin), .o_valid(v1), .i_ready(1'b1),
        .o_sum(sum1), .o_carry(c1), .o_ovf(ov1), .o_zero(z1), .o_neg(n1));

    pipe_addsub #(.WIDTH(8), .STAGES(2)) u_w8s2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(r2),
        .i_a(s_a[7:0]), .i_b(s_b[7:0]), .i_op(s_op), .i_cin(s_cin), .o_valid(v2), .i_ready(1'b1),
        .o_sum(sum2), .o_carry(c2), .o_ovf(ov2), .o_zero(z2), .o_neg(n2));

    pipe_addsub #(.WIDTH(64), .STAGES(8)) u_w64s8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(r8),
        .i_a(s_a), .i_b(s_b), .i_op(s_op), .i_cin(s_cin), .o_valid(v8), .i_ready(1'b1),
        .o_sum(sum8), .o_carry(c8), .o_ovf(ov8), .o_zero(z8), .o_neg(n8));

    // Observed results packed as {carry, ovf, zero, neg, sum zero-extended to 64}.
    logic [67:0] obs32, obs1, obs2, obs8;
    assign obs32 = {o_carry, o_ovf, o_zero, o_neg, 32'd0, o_sum};
    assign obs1  = {c1, ov1, z1, n1, 56'd0, sum1};
    assign obs2  = {c2, ov2, z2, n2, 56'd0, sum2};
    assign obs8  = {c8, ov8, z8, n8, sum8};

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [67:0] model(input int w, input logic [63:0] ma, input logic [63:0] mb,
                                          input logic [1:0] mop, input logic mc);
        logic [63:0] mask, aa, bb, s;
        logic [64:0] sum_full;
        logic        c0, cy, ov;
        mask     = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        aa       = ma & mask;
        bb       = (mop[0] ? ~mb : mb) & mask;
        c0       = mop[1] ? mc : mop[0];
        sum_full = {1'b0, aa} + {1'b0, bb} + {64'd0, c0};
        s        = sum_full[63:0] & mask;
        cy       = sum_full[w];
        ov       = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {cy, ov, (s == 64'd0), s[w-1], s};
    endfunction

    task automatic send32(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                          input logic tc, output int lat);
        @(negedge clk);
        valid = 1'b1; a = ta; b = tb; op = top; cin = tc;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        valid = 1'b0;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    logic [67:0] q[$], q1[$], q2[$], q8[$];
    logic [67:0] held;
    int          lat, sent, got;
    logic        need_new, hold, stall_seen, stale;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; valid = 1'b0; ready_in = 1'b1; a = '0; b = '0; op = '0; cin = 1'b0;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_op = '0; s_cin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_outs", obs32, {1'b0, 1'b0, 1'b1, 1'b0, 64'h0});

        send32(32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0, lat);
        check("add_lat", lat, 4);
        check("add_wrap", obs32, {1'b1, 1'b0, 1'b1, 1'b0, 64'h0});
        send32(32'h8000_0000, 32'h1, 2'b01, 1'b0, lat);
        check("sub_ovf", obs32, {1'b1, 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF});
        send32(32'h5, 32'h3, 2'b11, 1'b0, lat);
        check("sbc_c0", obs32, {1'b1, 1'b0, 1'b0, 1'b0, 64'h1});
        send32(32'h5, 32'h3, 2'b11, 1'b1, lat);
        check("sbc_c1", obs32, {1'b1, 1'b0, 1'b0, 1'b0, 64'h2});
        send32(32'h0000_FFFF, 32'h1, 2'b10, 1'b1, lat);
        check("adc_c1", obs32, {1'b0, 1'b0, 1'b0, 1'b0, 64'h1_0001});
        send32(32'h2, 32'h3, 2'b00, 1'b1, lat);
        check("add_cin_ign", obs32, {1'b0, 1'b0, 1'b0, 1'b0, 64'h5});
        send32(32'h5, 32'h5, 2'b01, 1'b1, lat);
        check("sub_zero", obs32, {1'b1, 1'b0, 1'b1, 1'b0, 64'h0});
        send32(32'h1, 32'h2, 2'b01, 1'b0, lat);
        check("sub_borrow", obs32, {1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF});

        // Streaming with a 6-cycle downstream stall.
        sent = 0; got = 0; need_new = 1'b1; hold = 1'b0; stall_seen = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            @(negedge clk);
            ready_in = !(cyc >= 3 && cyc < 9);
            if (sent < 10 && need_new) begin
                a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
                need_new = 1'b0;
            end
            valid = (sent < 10);
            #1;
            if (o_valid && !ready_in) begin
                if (hold) check("stall_stable", obs32, held);
                hold = 1'b1;
                held = obs32;
            end else begin
                hold = 1'b0;
            end
            if (!o_ready && !stall_seen) begin
                stall_seen = 1'b1;
                check("full_depth", q.size(), 4);
            end
            if (o_valid && ready_in) begin
                check("stream_res", obs32, q.pop_front());
                got++;
            end
            if (valid && o_ready) begin
                q.push_back(model(32, {32'd0, a}, {32'd0, b}, op, cin));
                sent++;
                need_new = 1'b1;
            end
        end
        valid = 1'b0; ready_in = 1'b1;
        check("stream_count", got, 10);
        check("stall_seen", stall_seen, 1'b1);

        // Asynchronous reset with beats in flight.
        @(negedge clk);
        ready_in = 1'b0; valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; op = 2'b00; cin = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_valid", o_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", o_valid, 1'b0);
        check("arst_ready", o_ready, 1'b1);
        check("arst_outs", obs32, {1'b0, 1'b0, 1'b1, 1'b0, 64'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ready_in = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_valid) stale = 1'b1;
        end
        check("no_stale", stale, 1'b0);
        send32(32'h7, 32'h8, 2'b00, 1'b0, lat);
        check("post_rst_lat", lat, 4);
        check("post_rst_res", obs32, {1'b0, 1'b0, 1'b0, 1'b0, 64'hF});

        // Narrow and wide variants: 8-bit signed overflow and single-stage latency.
        @(negedge clk);
        s_valid = 1'b1; s_a = 64'h7F; s_b = 64'h1; s_op = 2'b00; s_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        check("s1_lat1", v1, 1'b1);
        check("s1_7f01", obs1, {1'b0, 1'b1, 1'b0, 1'b1, 64'h80});
        check("s2_not_yet", v2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("s2_lat2", v2, 1'b1);
        check("s2_7f01", obs2, {1'b0, 1'b1, 1'b0, 1'b1, 64'h80});
        repeat (8) @(negedge clk);

        @(negedge clk);
        s_valid = 1'b1; s_a = 64'hFFFF_FFFF_FFFF_FFFF; s_b = 64'h1; s_op = 2'b00;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        s_valid = 1'b0;
        while (!v8 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("s8_lat", lat, 8);
        check("s8_wrap", obs8, {1'b1, 1'b0, 1'b1, 1'b0, 64'h0});
        @(negedge clk);

        sent = 0;
        for (int cyc = 0; cyc < 200 && (sent < 30 || q1.size() != 0 || q2.size() != 0 || q8.size() != 0); cyc++) begin
            @(negedge clk);
            if (v1) check("s1_rand", obs1, q1.pop_front());
            if (v2) check("s2_rand", obs2, q2.pop_front());
            if (v8) check("s8_rand", obs8, q8.pop_front());
            if (sent < 30) begin
                s_valid = 1'b1;
                s_a  = (sent % 5 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
                s_b  = (sent % 7 == 0) ? 64'h0 : {$urandom, $urandom};
                s_op = 2'($urandom_range(0, 3));
                s_cin = 1'($urandom_range(0, 1));
                q1.push_back(model(8, s_a, s_b, s_op, s_cin));
                q2.push_back(model(8, s_a, s_b, s_op, s_cin));
                q8.push_back(model(64, s_a, s_b, s_op, s_cin));
                sent++;
            end else begin
                s_valid = 1'b0;
            end
        end
        check("sweep_drain", q1.size() + q2.size() + q8.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
